// File: rtl/lsb_encoder.sv
// lsb_encoder: steganographic LSB encoder.
//
// Embeds a byte-stream message into the low BPB bits of a cover-image byte stream.
// Output frame layout:
//   - a LEN_W-bit length header (payload length in bits, MSB byte first);
//   - the payload, each byte split MSB-chunk-first over 8/BPB cover bytes;
//   - the remaining cover bytes, passed through unmodified.
//
// Optional feature (macro LSB_ENC_CHECKSUM_EN): after the payload, one extra byte holding
// the XOR of all payload bytes is embedded. The header length does not count this byte.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start, len_bits                   begin a frame (IDLE only), payload length in bits
//   cover_in/valid/last/ready         cover byte stream (input)
//   msg_in/valid/ready                payload byte stream (input)
//   stego_out/valid/last/ready        stego byte stream (output, 1-deep register)
//   busy                              high from start until done
//   done                              1-cycle pulse when the final stego byte is accepted
//   err                               sticky: cover ended before embedding completed

module lsb_encoder #(
    parameter int unsigned BPB   = 2,
    parameter int unsigned LEN_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len_bits,
    input  logic [7:0]       cover_in,
    input  logic             cover_valid,
    input  logic             cover_last,
    output logic             cover_ready,
    input  logic [7:0]       msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [7:0]       stego_out,
    output logic             stego_valid,
    output logic             stego_last,
    input  logic             stego_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned NChunk = 8 / BPB;
    localparam int unsigned NHdr   = LEN_W / 8;
    localparam int unsigned CntW   = LEN_W - 3;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoad,
        StEmbed,
        StPass,
        StDone
`ifdef LSB_ENC_CHECKSUM_EN
        , StCsum
`endif
    } state_e;

    state_e           state_q;
    logic [7:0]       sreg_q;
    logic [2:0]       chunk_q;
    logic [7:0]       hdr_idx_q;
    logic [CntW-1:0]  byte_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       stego_out_q;
    logic             stego_valid_q;
    logic             stego_last_q;
    logic             done_q;
    logic             err_q;
`ifdef LSB_ENC_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    logic            out_free;
    logic            embed_st;
    logic            cover_fire;
    logic            msg_fire;
    logic            chunk_end;
    logic            hdr_end;
    logic            pay_end;
    logic [7:0]      embed_byte;
    logic [CntW-1:0] pay_bytes;
    logic [CntW-1:0] byte_cnt_inc;

    // Header byte idx (0 = most significant byte of the length field).
    function automatic logic [7:0] hdr_byte(input logic [LEN_W-1:0] len, input int unsigned idx);
        logic [LEN_W-1:0] sh;
        sh = len >> (8 * (NHdr - 1 - idx));
        return sh[7:0];
    endfunction

    // States that consume cover bytes.
    always_comb begin
        embed_st = 1'b0;
        case (state_q)
            StHdr, StEmbed, StPass: embed_st = 1'b1;
`ifdef LSB_ENC_CHECKSUM_EN
            StCsum:                 embed_st = 1'b1;
`endif
            default:                embed_st = 1'b0;
        endcase
    end

    // The stego register can take a new byte when empty or draining this cycle.
    assign out_free     = !stego_valid_q || stego_ready;
    assign cover_ready  = embed_st && out_free;
    assign msg_ready    = (state_q == StLoad);
    assign cover_fire   = cover_valid && cover_ready;
    assign msg_fire     = msg_valid && msg_ready;
    assign chunk_end    = (chunk_q == 3'(NChunk - 1));
    assign hdr_end      = (hdr_idx_q == 8'(NHdr - 1));
    assign pay_bytes    = len_q[LEN_W-1:3];
    assign byte_cnt_inc = byte_cnt_q + CntW'(1);
    assign pay_end      = (byte_cnt_inc == pay_bytes);
    assign embed_byte   = {cover_in[7:BPB], sreg_q[7:8-BPB]};

    assign stego_out   = stego_out_q;
    assign stego_valid = stego_valid_q;
    assign stego_last  = stego_last_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            sreg_q        <= 8'h00;
            chunk_q       <= 3'd0;
            hdr_idx_q     <= 8'd0;
            byte_cnt_q    <= '0;
            len_q         <= '0;
            stego_out_q   <= 8'h00;
            stego_valid_q <= 1'b0;
            stego_last_q  <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef LSB_ENC_CHECKSUM_EN
            csum_q        <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;

            // Output register: drain on accept, refill on every accepted cover byte.
            if (stego_valid_q && stego_ready) begin
                stego_valid_q <= 1'b0;
                stego_last_q  <= 1'b0;
            end
            if (cover_fire) begin
                stego_valid_q <= 1'b1;
                stego_last_q  <= cover_last;
                stego_out_q   <= (state_q == StPass) ? cover_in : embed_byte;
            end

            // Chunk shifting is common to all embedding states.
            if (cover_fire && state_q != StPass) begin
                sreg_q  <= sreg_q << BPB;
                chunk_q <= chunk_end ? 3'd0 : chunk_q + 3'd1;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q      <= len_bits;
                        sreg_q     <= hdr_byte(len_bits, 0);
                        chunk_q    <= 3'd0;
                        hdr_idx_q  <= 8'd0;
                        byte_cnt_q <= '0;
                        err_q      <= 1'b0;
`ifdef LSB_ENC_CHECKSUM_EN
                        csum_q     <= 8'h00;
`endif
                        state_q    <= StHdr;
                    end
                end

                StHdr: begin
                    if (cover_fire) begin
                        if (cover_last) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else if (chunk_end) begin
                            if (!hdr_end) begin
                                hdr_idx_q <= hdr_idx_q + 8'd1;
                                sreg_q    <= hdr_byte(len_q, 32'(hdr_idx_q) + 1);
                            end else if (pay_bytes != '0) begin
                                state_q <= StLoad;
                            end else begin
`ifdef LSB_ENC_CHECKSUM_EN
                                // Empty payload still carries a zero checksum byte.
                                sreg_q  <= 8'h00;
                                state_q <= StCsum;
`else
                                state_q <= StPass;
`endif
                            end
                        end
                    end
                end

                StLoad: begin
                    if (msg_fire) begin
                        sreg_q  <= msg_in;
`ifdef LSB_ENC_CHECKSUM_EN
                        csum_q  <= csum_q ^ msg_in;
`endif
                        state_q <= StEmbed;
                    end
                end

                StEmbed: begin
                    if (cover_fire) begin
                        if (cover_last) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else if (chunk_end) begin
                            byte_cnt_q <= byte_cnt_inc;
                            if (pay_end) begin
`ifdef LSB_ENC_CHECKSUM_EN
                                sreg_q  <= csum_q;
                                state_q <= StCsum;
`else
                                state_q <= StPass;
`endif
                            end else begin
                                state_q <= StLoad;
                            end
                        end
                    end
                end

`ifdef LSB_ENC_CHECKSUM_EN
                StCsum: begin
                    if (cover_fire) begin
                        if (cover_last) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else if (chunk_end) begin
                            state_q <= StPass;
                        end
                    end
                end
`endif

                StPass: begin
                    if (cover_fire && cover_last) begin
                        state_q <= StDone;
                    end
                end

                StDone: begin
                    if (stego_valid_q && stego_ready && stego_last_q) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
